// File: rtl/clockgen_pkg.sv
// Shared defaults and helpers for the clockgen_multi timing generator.
package clockgen_pkg;

   localparam int unsigned NTAPS_DEF    = 8;
   localparam int unsigned LEN_SLOW_DEF = 16;
   localparam int unsigned LEN_FAST_DEF = 8;

   function automatic int unsigned phase_w(input int unsigned len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

   // Tap k is high for the half of the cycle starting k phases after phase 0.
   function automatic logic tap_on(input int unsigned ph, input int unsigned k,
                                   input int unsigned len);
      return ((ph + 2 * len - k) % len) < (len / 2);
   endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One programmable clock-enable divider channel; reload values take effect only at
// the next natural reload so a running period is never cut short.
module clkdiv_chan #(
   parameter int unsigned DIVW = 8
) (
   input  logic            clk32,
   input  logic            res,
   input  logic            mcyc,
   input  logic            ld,
   input  logic [DIVW-1:0] val,
   output logic            ack,
   output logic            en
);

   logic [DIVW-1:0] cnt_q, cnt_d;
   logic [DIVW-1:0] rel_q, rel_d;
   logic [DIVW-1:0] pend_q, pend_d;
   logic            pv_q, pv_d;
   logic            en_d;

   always_comb begin
      cnt_d  = cnt_q;
      rel_d  = rel_q;
      pend_d = pend_q;
      pv_d   = pv_q;
      en_d   = 1'b0;
      if (mcyc) begin
         if (cnt_q == '0) begin
            en_d = 1'b1;
            if (pv_q) begin
               rel_d = pend_q;
               cnt_d = pend_q;
               pv_d  = 1'b0;
            end else begin
               cnt_d = rel_q;
            end
         end else begin
            cnt_d = cnt_q - DIVW'(1);
         end
      end
      // A load coinciding with a reload stays pending for the following one.
      if (ld) begin
         pend_d = val;
         pv_d   = 1'b1;
      end
   end

   always_ff @(posedge clk32 or posedge res) begin
      if (res) begin
         cnt_q  <= '0;
         rel_q  <= '0;
         pend_q <= '0;
         pv_q   <= 1'b0;
         ack    <= 1'b0;
         en     <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rel_q  <= rel_d;
         pend_q <= pend_d;
         pv_q   <= pv_d;
         ack    <= ld;
         en     <= en_d;
      end
   end

endmodule

// File: rtl/clockgen_multi.sv
// Memory-cycle timing generator: phase counter, staggered taps, latch strobe and
// NCH divider channels. Define CLOCKGEN_TURBO_EN to honour the turbo request.
module clockgen_multi
   import clockgen_pkg::*;
#(
   parameter int unsigned NTAPS    = NTAPS_DEF,
   parameter int unsigned LEN_SLOW = LEN_SLOW_DEF,
   parameter int unsigned LEN_FAST = LEN_FAST_DEF,
   parameter int unsigned LATCH_A  = 5,
   parameter int unsigned LATCH_B  = 1,
   parameter int unsigned NCH      = 2,
   parameter int unsigned DIVW     = 8
) (
   input  logic                 clk32,
   input  logic                 res,
   input  logic                 turbo,
   output logic                 clk16,
   output logic [NTAPS-1:0]     time_tap,
   output logic                 latch,
   output logic                 mcyc_start,
   output logic                 turbo_act,
   input  logic [NCH-1:0]       div_ld,
   input  logic [NCH*DIVW-1:0]  div_val,
   output logic [NCH-1:0]       div_ack,
   output logic [NCH-1:0]       ch_en
);

   localparam int unsigned   PW        = phase_w(LEN_SLOW);
   localparam logic [PW-1:0] SLOW_LAST = PW'(LEN_SLOW - 1);

   logic [PW-1:0]    ph_q, ph_d;
   logic [PW-1:0]    last_ph;
   logic             turbo_act_q, turbo_act_d;
   int unsigned      len_d;
   logic [NTAPS-1:0] tap_d;
   logic             start_d;

`ifdef CLOCKGEN_TURBO_EN
   localparam logic [PW-1:0] FAST_LAST = PW'(LEN_FAST - 1);

   // Mode only changes at the wrap, so every memory cycle is full length.
   assign last_ph     = turbo_act_q ? FAST_LAST : SLOW_LAST;
   assign turbo_act_d = (ph_q == last_ph) ? turbo : turbo_act_q;
   assign len_d       = turbo_act_d ? LEN_FAST : LEN_SLOW;
`else
   logic [32:0] unused_cfg;
   assign unused_cfg  = {turbo, LEN_FAST};
   assign last_ph     = SLOW_LAST;
   assign turbo_act_d = 1'b0;
   assign len_d       = LEN_SLOW;
`endif

   always_comb begin
      ph_d    = (ph_q == last_ph) ? '0 : ph_q + PW'(1);
      start_d = (ph_d == '0);
      tap_d   = '0;
      for (int unsigned k = 0; k < NTAPS; k++) begin
         tap_d[k] = tap_on(32'(ph_d), k, len_d);
      end
   end

   // Outputs are decoded from the incoming phase so they align with ph_q.
   always_ff @(posedge clk32 or posedge res) begin
      if (res) begin
         ph_q        <= SLOW_LAST;
         turbo_act_q <= 1'b0;
         clk16       <= 1'b0;
         time_tap    <= '0;
         latch       <= 1'b0;
         mcyc_start  <= 1'b0;
      end else begin
         ph_q        <= ph_d;
         turbo_act_q <= turbo_act_d;
         clk16       <= ~clk16;
         time_tap    <= tap_d;
         latch       <= tap_d[LATCH_A] & ~tap_d[LATCH_B];
         mcyc_start  <= start_d;
      end
   end

   assign turbo_act = turbo_act_q;

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      clkdiv_chan #(
         .DIVW(DIVW)
      ) u_chan (
         .clk32(clk32),
         .res  (res),
         .mcyc (start_d),
         .ld   (div_ld[c]),
         .val  (div_val[c*DIVW +: DIVW]),
         .ack  (div_ack[c]),
         .en   (ch_en[c])
      );
   end

endmodule

// File: tb/tb_clockgen_multi.sv
// Self-checking bench for clockgen_multi: cycle model feeding a scoreboard queue plus
// directed period/phase checks.
module tb_clockgen_multi;

   localparam int NTAPS = 8;
   localparam int LS    = 16;
   localparam int LF    = 8;
   localparam int LA    = 5;
   localparam int LB    = 1;
   localparam int NCH   = 2;
   localparam int DIVW  = 8;
   localparam int OW    = 1 + NTAPS + 3 + 2 * NCH;
`ifdef CLOCKGEN_TURBO_EN
   localparam bit TURBO = 1'b1;
`else
   localparam bit TURBO = 1'b0;
`endif

   logic                clk32 = 1'b0;
   logic                res   = 1'b1;
   logic                turbo = 1'b0;
   logic [NCH-1:0]      div_ld  = '0;
   logic [NCH*DIVW-1:0] div_val = '0;
   logic                clk16, latch, mcyc_start, turbo_act;
   logic [NTAPS-1:0]    time_tap;
   logic [NCH-1:0]      div_ack, ch_en;
   logic [OW-1:0]       obs_vec;

   clockgen_multi dut (
      .clk32     (clk32),
      .res       (res),
      .turbo     (turbo),
      .clk16     (clk16),
      .time_tap  (time_tap),
      .latch     (latch),
      .mcyc_start(mcyc_start),
      .turbo_act (turbo_act),
      .div_ld    (div_ld),
      .div_val   (div_val),
      .div_ack   (div_ack),
      .ch_en     (ch_en)
   );

   assign obs_vec = {clk16, time_tap, latch, mcyc_start, turbo_act, div_ack, ch_en};

   always #5 clk32 = ~clk32;

   int            checks = 0;
   int            errors = 0;
   logic [OW-1:0] exp_q[$];

   // Reference model state
   int m_ph;
   bit m_ta;
   bit m_clk;
   int m_cnt[NCH];
   int m_rel[NCH];
   int m_pend[NCH];
   bit m_pv[NCH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph  = LS - 1;
      m_ta  = 1'b0;
      m_clk = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c]  = 0;
         m_rel[c]  = 0;
         m_pend[c] = 0;
         m_pv[c]   = 1'b0;
      end
   endtask

   task automatic model_step(output logic [OW-1:0] e);
      int               len;
      logic [NTAPS-1:0] t;
      logic [NCH-1:0]   ack;
      logic [NCH-1:0]   en;
      bit               st;
      if (res) begin
         model_reset();
         e = '0;
         return;
      end
      len = m_ta ? LF : LS;
      if (m_ph == len - 1) begin
         if (TURBO) m_ta = turbo;
         m_ph = 0;
      end else begin
         m_ph++;
      end
      len = m_ta ? LF : LS;
      for (int k = 0; k < NTAPS; k++) t[k] = ((m_ph + 2 * len - k) % len) < (len / 2);
      st    = (m_ph == 0);
      m_clk = ~m_clk;
      for (int c = 0; c < NCH; c++) begin
         ack[c] = div_ld[c];
         en[c]  = 1'b0;
         if (st) begin
            if (m_cnt[c] == 0) begin
               en[c] = 1'b1;
               if (m_pv[c]) begin
                  m_rel[c] = m_pend[c];
                  m_pv[c]  = 1'b0;
               end
               m_cnt[c] = m_rel[c];
            end else begin
               m_cnt[c]--;
            end
         end
         if (div_ld[c]) begin
            m_pend[c] = int'(div_val[c*DIVW +: DIVW]);
            m_pv[c]   = 1'b1;
         end
      end
      e = {m_clk, t, t[LA] & ~t[LB], st, m_ta, ack, en};
   endtask

   task automatic tick();
      logic [OW-1:0] e;
      model_step(e);
      exp_q.push_back(e);
      @(posedge clk32);
      #1;
      e = exp_q.pop_front();
      check("cycle_outputs", 32'(obs_vec), 32'(e));
   endtask

   task automatic run_to_start(output int n);
      n = -1;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (mcyc_start) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_to_en(input int c, output int starts);
      int s;
      s      = 0;
      starts = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (mcyc_start) s++;
         if (ch_en[c]) begin
            starts = s;
            break;
         end
      end
   endtask

   initial begin
      int            n;
      logic [LS-1:0] m_latch, m_t0, m_t3, m_st;

      // Reset state
      model_reset();
      #12;
      check("reset_outputs", 32'(obs_vec), 32'd0);
      @(posedge clk32);
      #1;
      res = 1'b0;
      tick();
      check("first_start", 32'(mcyc_start), 32'd1);

      // Tap and latch phases over one normal cycle (index = phase)
      m_latch = '0; m_t0 = '0; m_t3 = '0; m_st = '0;
      for (int i = 1; i <= LS; i++) begin
         tick();
         m_latch[i % LS] = latch;
         m_t0[i % LS]    = time_tap[0];
         m_t3[i % LS]    = time_tap[3];
         m_st[i % LS]    = mcyc_start;
      end
      check("latch_phases", 32'(m_latch), 32'h1E00);
      check("time0_phases", 32'(m_t0), 32'h00FF);
      check("time3_phases", 32'(m_t3), 32'h07F8);
      check("start_phases", 32'(m_st), 32'h0001);

      // Turbo raised at ph 4, dropped at ph 3
      for (int i = 0; i < 4; i++) tick();
      turbo = 1'b1;
      run_to_start(n);
      check("turbo_finish_slow", 32'(n), 32'd12);
      check("turbo_act_on", 32'(turbo_act), 32'(TURBO));
      run_to_start(n);
      check("turbo_period", 32'(n), TURBO ? 32'd8 : 32'd16);
      for (int i = 0; i < 3; i++) tick();
      turbo = 1'b0;
      run_to_start(n);
      check("turbo_finish_fast", 32'(n), TURBO ? 32'd5 : 32'd13);
      check("turbo_act_off", 32'(turbo_act), 32'd0);
      run_to_start(n);
      check("slow_period_again", 32'(n), 32'd16);

      // Channel 0 reload to 3
      div_val[0 +: DIVW] = 8'd3;
      div_ld[0] = 1'b1;
      tick();
      div_ld[0] = 1'b0;
      check("ack0", 32'(div_ack[0]), 32'd1);
      tick();
      check("ack0_drop", 32'(div_ack[0]), 32'd0);
      run_to_en(0, n);
      check("ch0_reload", 32'(n), 32'd1);
      run_to_en(0, n);
      check("ch0_period_a", 32'(n), 32'd4);
      run_to_en(0, n);
      check("ch0_period_b", 32'(n), 32'd4);

      // Channel 1: two loads in one period, last wins
      tick();
      div_val[DIVW +: DIVW] = 8'd1;
      div_ld[1] = 1'b1;
      tick();
      check("ack1_first", 32'(div_ack[1]), 32'd1);
      div_val[DIVW +: DIVW] = 8'd5;
      tick();
      check("ack1_second", 32'(div_ack[1]), 32'd1);
      div_ld[1] = 1'b0;
      run_to_en(1, n);
      check("ch1_reload", 32'(n), 32'd1);
      run_to_en(1, n);
      check("ch1_period", 32'(n), 32'd6);

      // Held load acked every cycle
      div_val[0 +: DIVW] = 8'd2;
      div_ld[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ack0_held", 32'(div_ack[0]), 32'd1);
      end
      div_ld[0] = 1'b0;

      // Asynchronous reset at ph 7
      for (int i = 0; i < 32 && m_ph != 7; i++) tick();
      check("reached_ph7", 32'(m_ph), 32'd7);
      #3;
      res = 1'b1;
      #1;
      check("reset_async", 32'(obs_vec), 32'd0);
      model_reset();
      tick();
      res = 1'b0;
      tick();
      check("restart_start", 32'(mcyc_start), 32'd1);
      run_to_start(n);
      check("restart_period", 32'(n), 32'd16);
      check("ch0_after_reset", 32'(ch_en[0]), 32'd1);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
